// File: rtl/irq_pending_encoder.sv
// Latched, handshaked 8-to-3 interrupt priority front-end with pending/mask registers.
// Define IRQ_LEVEL_MODE_EN for level-sensitive requests (no edge detect, no miss counting).
module irq_pending_encoder #(
  parameter logic [7:0] MASK_RESET = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       mask_we_i,
  input  logic [7:0] mask_din_i,
  input  logic       irq_ack_i,
  output logic       irq_valid_o,
  output logic [2:0] irq_id_o,
  output logic [7:0] pending_o,
  output logic [7:0] miss_cnt_o
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q;
  logic       irq_valid_q;
  logic [2:0] irq_id_q;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] cand;

  function automatic logic [2:0] top_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef IRQ_LEVEL_MODE_EN
  assign rise       = req_i;
  assign miss_cnt_o = 8'h00;
`else
  logic [7:0] req_q;
  logic [7:0] miss_q, miss_d;
  logic       miss_any;

  assign rise = req_i & ~req_q;

  always_comb begin
    // set wins over clear, so a rise on the bit being acked is not a miss
    miss_any = |(rise & pending_q & ~clr);
    miss_d   = miss_q;
    if (miss_any && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= 8'h00;
      miss_q <= 8'h00;
    end else begin
      req_q  <= req_i;
      miss_q <= miss_d;
    end
  end

  assign miss_cnt_o = miss_q;
`endif

  always_comb begin
    clr = 8'h00;
    if (irq_valid_q && irq_ack_i) clr = 8'h01 << irq_id_q;
    pending_d = (pending_q & ~clr) | rise;
    cand      = pending_q & ~mask_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 8'h00;
      mask_q    <= MASK_RESET;
    end else begin
      pending_q <= pending_d;
      if (mask_we_i) mask_q <= mask_din_i;
    end
  end

  // Selection uses the registered pending/mask, giving the 2-edge request latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cand != 8'h00) begin
            irq_id_q    <= top_idx(cand);
            irq_valid_q <= 1'b1;
            state_q     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (irq_ack_i) begin
            irq_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          irq_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign pending_o   = pending_q;

endmodule
